// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road intersection controller: state codes,
// lamp-vector bit positions and the per-state phase duration lookup.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        NIGHT     = 3'd6,
        ILLEGAL_7 = 3'd7
    } state_t;

    localparam int unsigned L_NS_R = 0;
    localparam int unsigned L_NS_Y = 1;
    localparam int unsigned L_NS_G = 2;
    localparam int unsigned L_EW_R = 3;
    localparam int unsigned L_EW_Y = 4;
    localparam int unsigned L_EW_G = 5;

    // Countdown load value on entry to a state; NIGHT holds at zero.
    function automatic int unsigned dur_of(input state_t s, input int unsigned green_s,
                                           input int unsigned yellow_s,
                                           input int unsigned all_red_s);
        case (s)
            NS_GREEN, EW_GREEN:   return green_s;
            NS_YELLOW, EW_YELLOW: return yellow_s;
            ALL_RED_A, ALL_RED_B: return all_red_s;
            default:              return 0;
        endcase
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_tick_gen.sv
// Parametrised clock divider producing a registered one-cycle tick at TICK_HZ.
module tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 1
) (
    input  logic clk_in,
    input  logic rst,
    output logic tick
);
    localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned CW  = (DIV >= 2) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("tick_gen: CLK_FREQ_HZ/TICK_HZ must be >= 2");
    end

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_q <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road (NS/EW) intersection controller: phase FSM with countdown,
// pedestrian shortening, night flashing-yellow mode and pre-yellow green blink.
module traffic_intersection_ctrl #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 1,
    parameter int unsigned GREEN_S     = 30,
    parameter int unsigned YELLOW_S    = 3,
    parameter int unsigned ALL_RED_S   = 2,
    parameter int unsigned PED_MIN_S   = 5,
    parameter int unsigned BLINK_S     = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             night_mode,
    input  logic             ped_req,
    output logic             ns_red,
    output logic             ns_yellow,
    output logic             ns_green,
    output logic             ew_red,
    output logic             ew_yellow,
    output logic             ew_green,
    output logic [2:0]       state,
    output logic             tick,
    output logic [CNT_W-1:0] countdown,
    output logic [3:0]       cd_tens,
    output logic [3:0]       cd_ones
);
    import traffic_pkg::*;

    if (GREEN_S < 1 || GREEN_S > 99 || YELLOW_S < 1 || YELLOW_S > 99 ||
        ALL_RED_S < 1 || ALL_RED_S > 99 || PED_MIN_S < 1 || PED_MIN_S > GREEN_S ||
        BLINK_S > GREEN_S || (2 ** CNT_W) <= 99) begin : g_bad_params
        $error("traffic_intersection_ctrl: duration or width parameter out of range");
    end

    tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .TICK_HZ    (TICK_HZ)
    ) u_tick_gen (
        .clk_in(clk_in),
        .rst   (rst),
        .tick  (tick)
    );

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             ped_q, ped_n;
    logic             blink_q, blink_n;
    logic [5:0]       lamps_q, lamps_n;
    logic             is_green;
    logic             enter_red;

    assign is_green = (state_q == NS_GREEN) || (state_q == EW_GREEN);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        blink_n = blink_q;
        if (state_q == ILLEGAL_7) begin
            state_n = ALL_RED_B;
            cnt_n   = CNT_W'(ALL_RED_S);
        end else if (tick) begin
            blink_n = ~blink_q;
            if (state_q == NIGHT) begin
                if (!night_mode) begin
                    state_n = ALL_RED_B;
                    cnt_n   = CNT_W'(ALL_RED_S);
                end
            end else if (cnt_q <= CNT_W'(1)) begin
                case (state_q)
                    NS_GREEN:  state_n = NS_YELLOW;
                    NS_YELLOW: state_n = ALL_RED_A;
                    ALL_RED_A: state_n = night_mode ? NIGHT : EW_GREEN;
                    EW_GREEN:  state_n = EW_YELLOW;
                    EW_YELLOW: state_n = ALL_RED_B;
                    ALL_RED_B: state_n = night_mode ? NIGHT : NS_GREEN;
                    default:   state_n = ALL_RED_B;
                endcase
                cnt_n = CNT_W'(dur_of(state_n, GREEN_S, YELLOW_S, ALL_RED_S));
            end else if (is_green && ped_q && cnt_q > CNT_W'(PED_MIN_S)) begin
                cnt_n = CNT_W'(PED_MIN_S);
            end else begin
                cnt_n = cnt_q - 1'b1;
            end
        end
        if (state_n != state_q) begin
            blink_n = 1'b1;
        end
    end

    // A request arriving in the very cycle of all-red entry survives the clear.
    assign enter_red = (state_n != state_q) && (state_n == ALL_RED_A || state_n == ALL_RED_B);
    assign ped_n     = ped_req | (ped_q & ~enter_red);

    // Lamps decode from the next state so they register alongside it.
    always_comb begin
        lamps_n = '0;
        case (state_n)
            NS_GREEN: begin
                lamps_n[L_NS_G] = (cnt_n <= CNT_W'(BLINK_S)) ? blink_n : 1'b1;
                lamps_n[L_EW_R] = 1'b1;
            end
            NS_YELLOW: begin
                lamps_n[L_NS_Y] = 1'b1;
                lamps_n[L_EW_R] = 1'b1;
            end
            EW_GREEN: begin
                lamps_n[L_EW_G] = (cnt_n <= CNT_W'(BLINK_S)) ? blink_n : 1'b1;
                lamps_n[L_NS_R] = 1'b1;
            end
            EW_YELLOW: begin
                lamps_n[L_EW_Y] = 1'b1;
                lamps_n[L_NS_R] = 1'b1;
            end
            NIGHT: begin
                lamps_n[L_NS_Y] = blink_n;
                lamps_n[L_EW_Y] = blink_n;
            end
            default: begin
                lamps_n[L_NS_R] = 1'b1;
                lamps_n[L_EW_R] = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q <= NS_GREEN;
            cnt_q   <= CNT_W'(GREEN_S);
            ped_q   <= 1'b0;
            blink_q <= 1'b1;
            lamps_q <= '0;
            lamps_q[L_NS_G] <= 1'b1;
            lamps_q[L_EW_R] <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            ped_q   <= ped_n;
            blink_q <= blink_n;
            lamps_q <= lamps_n;
        end
    end

    assign state     = state_q;
    assign countdown = cnt_q;
    assign cd_tens   = 4'(cnt_q / CNT_W'(10));
    assign cd_ones   = 4'(cnt_q % CNT_W'(10));

    assign ns_red    = lamps_q[L_NS_R];
    assign ns_yellow = lamps_q[L_NS_Y];
    assign ns_green  = lamps_q[L_NS_G];
    assign ew_red    = lamps_q[L_EW_R];
    assign ew_yellow = lamps_q[L_EW_Y];
    assign ew_green  = lamps_q[L_EW_G];

endmodule
